// File: rtl/ftdi_stream_bridge.sv
// Bridges an FTDI-style request/strobe byte interface to valid/ready streams,
// with one DEPTH-entry byte FIFO per direction.
module ftdi_stream_bridge #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock_in,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_rq,
    output logic          rx_st,
    output logic [7:0]    tx_data,
    output logic          tx_rq,
    input  logic          tx_st,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [AW:0]   rx_level,
    output logic [AW:0]   tx_level
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {R_IDLE, R_ACK} rx_state_e;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT} tx_state_e;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];

    rx_state_e     rx_state_q, rx_state_d;
    tx_state_e     tx_state_q, tx_state_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic          rx_st_q, rx_st_d;
    logic          tx_rq_q, tx_rq_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          rx_push, rx_pop, tx_push, tx_pop;

    assign m_valid  = (rx_cnt_q != '0);
    assign m_data   = rx_mem[rx_rp_q];
    assign s_ready  = (tx_cnt_q != FULL);
    assign rx_level = rx_cnt_q;
    assign tx_level = tx_cnt_q;
    assign rx_st    = rx_st_q;
    assign tx_rq    = tx_rq_q;
    assign tx_data  = tx_data_q;
    assign rx_pop   = m_valid & m_ready;
    assign tx_push  = s_valid & s_ready;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_st_d    = rx_st_q;
        rx_push    = 1'b0;
        // Full test uses the pre-edge count, so a pop on the same clock defers the write.
        case (rx_state_q)
            R_IDLE: if (rx_rq && rx_cnt_q != FULL) begin
                rx_push    = 1'b1;
                rx_st_d    = 1'b1;
                rx_state_d = R_ACK;
            end
            R_ACK: if (!rx_rq) begin
                rx_st_d    = 1'b0;
                rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
        rx_wp_d  = rx_wp_q + AW'(rx_push);
        rx_rp_d  = rx_rp_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_rq_d    = tx_rq_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            T_IDLE: if (tx_cnt_q != '0) begin
                tx_data_d  = tx_mem[tx_rp_q];
                tx_pop     = 1'b1;
                tx_rq_d    = 1'b1;
                tx_state_d = T_REQ;
            end
            T_REQ: if (tx_st) begin
                tx_rq_d    = 1'b0;
                tx_state_d = T_WAIT;
            end
            T_WAIT: if (!tx_st) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
        tx_wp_d  = tx_wp_q + AW'(tx_push);
        tx_rp_d  = tx_rp_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end

    always_ff @(posedge clock_in) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
        if (tx_push) tx_mem[tx_wp_q] <= s_data;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            rx_state_q <= R_IDLE;
            tx_state_q <= T_IDLE;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            rx_st_q    <= 1'b0;
            tx_rq_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_st_q    <= rx_st_d;
            tx_rq_q    <= tx_rq_d;
            tx_data_q  <= tx_data_d;
        end
    end
endmodule

// File: tb/tb_ftdi_stream_bridge.sv
// Self-checking bench for ftdi_stream_bridge: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ftdi_stream_bridge;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_rq = 1'b0;
    logic          rx_st;
    logic [7:0]    tx_data;
    logic          tx_rq;
    logic          tx_st = 1'b0;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW:0]   rx_level, tx_level;

    int n_cmp = 0;
    int n_err = 0;

    ftdi_stream_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock_in(clk), .reset(rst),
        .rx_data(rx_data), .rx_rq(rx_rq), .rx_st(rx_st),
        .tx_data(tx_data), .tx_rq(tx_rq), .tx_st(tx_st),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .rx_level(rx_level), .tx_level(tx_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queues plus handshake progress flags.
    logic [7:0] mrx[$];
    logic [7:0] mtx[$];
    bit         rx_pending;
    bit         tx_offered;
    bit         tx_release;
    logic       e_rx_st = 1'b0;
    logic       e_tx_rq = 1'b0;
    logic [7:0] e_tx_data = '0;
    int         rn, tn;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mrx.delete();
            mtx.delete();
            rx_pending = 0;
            tx_offered = 0;
            tx_release = 0;
            e_rx_st    = 1'b0;
            e_tx_rq    = 1'b0;
            e_tx_data  = '0;
        end else begin
            rn = mrx.size();
            tn = mtx.size();
            if (rn != 0 && m_ready) void'(mrx.pop_front());
            if (rx_pending) begin
                if (!rx_rq) rx_pending = 0;
            end else if (rx_rq && rn < DEPTH) begin
                mrx.push_back(rx_data);
                rx_pending = 1;
            end
            e_rx_st = rx_pending;

            if (tx_offered) begin
                if (tx_st) begin tx_offered = 0; tx_release = 1; end
            end else if (tx_release) begin
                if (!tx_st) tx_release = 0;
            end else if (tn != 0) begin
                e_tx_data  = mtx.pop_front();
                tx_offered = 1;
            end
            e_tx_rq = tx_offered;
            if (s_valid && tn < DEPTH) mtx.push_back(s_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", int'(m_valid), int'(mrx.size() != 0));
            if (mrx.size() != 0) chk("m_data", int'(m_data), int'(mrx[0]));
            chk("rx_level", int'(rx_level), mrx.size());
            chk("rx_st", int'(rx_st), int'(e_rx_st));
            chk("s_ready", int'(s_ready), int'(mtx.size() < DEPTH));
            chk("tx_level", int'(tx_level), mtx.size());
            chk("tx_rq", int'(tx_rq), int'(e_tx_rq));
            chk("tx_data", int'(tx_data), int'(e_tx_data));
        end
    end

    // Logs of what crossed each interface, for ordering checks.
    logic [7:0] m_log[$];
    logic [7:0] tx_seen[$];
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) m_log.push_back(m_data);
    end

    // FTDI transmit-side responder.
    bit resp_en  = 0;
    bit resp_rnd = 0;
    int resp_dly = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            tx_st    = 1'b0;
            resp_dly = 0;
        end else if (tx_st) begin
            if (!tx_rq) tx_st = 1'b0;
        end else if (tx_rq && resp_en) begin
            if (resp_dly == 0) begin
                tx_st = 1'b1;
                tx_seen.push_back(tx_data);
                resp_dly = resp_rnd ? int'($urandom_range(0, 2)) : 0;
            end else begin
                resp_dly--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ftdi_send(input logic [7:0] b);
        bit ok;
        rx_data = b;
        rx_rq   = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (rx_st) begin ok = 1; break; end
        end
        chk("rx_ack_seen", int'(ok), 1);
        rx_rq = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!rx_st) begin ok = 1; break; end
        end
        chk("rx_ack_release", int'(ok), 1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok;
        s_data  = b;
        s_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1; tick(); break; end
            tick();
        end
        s_valid = 1'b0;
        chk("s_push_accepted", int'(ok), 1);
    endtask

    task automatic wait_tx_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (tx_level == '0 && !tx_rq && !tx_st) begin ok = 1; break; end
        end
        tick();
        tick();
        chk("tx_drain", int'(ok), 1);
    endtask

    task automatic wait_m_log(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (m_log.size() >= n) begin ok = 1; break; end
            tick();
        end
        chk("rx_drain", int'(ok), 1);
    endtask

    logic [7:0] sent_rx[$];
    logic [7:0] sent_tx[$];
    logic [7:0] b;

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_rx_st", int'(rx_st), 0);
        chk("rst_tx_rq", int'(tx_rq), 0);
        chk("rst_tx_data", int'(tx_data), 8'h00);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_rx_level", int'(rx_level), 0);
        chk("rst_tx_level", int'(tx_level), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Single RX byte with the consumer ready.
        m_ready = 1'b1;
        rx_data = 8'hA5;
        rx_rq   = 1'b1;
        tick();
        chk("single_rx_st", int'(rx_st), 1);
        chk("single_m_valid", int'(m_valid), 1);
        chk("single_m_data", int'(m_data), 8'hA5);
        rx_rq = 1'b0;
        tick();
        chk("single_rx_st_low", int'(rx_st), 0);
        chk("single_m_empty", int'(m_valid), 0);
        tick();

        // Fill RX to DEPTH, 17th byte held off until space appears.
        m_ready = 1'b0;
        m_log.delete();
        for (int i = 0; i < 16; i++) ftdi_send(8'(i));
        chk("rx_full_level", int'(rx_level), 16);
        rx_data = 8'h10;
        rx_rq   = 1'b1;
        repeat (5) tick();
        chk("rx_full_no_ack", int'(rx_st), 0);
        chk("rx_full_hold", int'(rx_level), 16);
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rx_st) break;
            tick();
        end
        chk("rx_17th_acked", int'(rx_st), 1);
        rx_rq = 1'b0;
        wait_m_log(17);
        tick();
        chk("rx_order_count", m_log.size(), 17);
        for (int i = 0; i < 17 && i < m_log.size(); i++)
            chk("rx_order", int'(m_log[i]), i);

        // TX burst of three with the FTDI strobing.
        resp_en = 1;
        tx_seen.delete();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        wait_tx_drain();
        chk("tx_burst_count", tx_seen.size(), 3);
        for (int i = 0; i < 3 && i < tx_seen.size(); i++)
            chk("tx_burst_data", int'(tx_seen[i]), i + 1);
        chk("tx_burst_level", int'(tx_level), 0);

        // TX fill: one byte parked on tx_data, 16 in the FIFO.
        resp_en = 0;
        tx_seen.delete();
        sent_tx.delete();
        for (int i = 0; i < 17; i++) begin
            sent_tx.push_back(8'h40 + 8'(i));
            push_byte(8'h40 + 8'(i));
        end
        chk("tx_full_level", int'(tx_level), 16);
        chk("tx_full_ready", int'(s_ready), 0);
        s_data  = 8'hEE;
        s_valid = 1'b1;
        repeat (4) tick();
        chk("tx_full_hold", int'(tx_level), 16);
        s_valid = 1'b0;
        resp_en = 1;
        for (int i = 0; i < 20; i++) begin
            if (s_ready) break;
            tick();
        end
        chk("tx_ready_again", int'(s_ready), 1);
        wait_tx_drain();
        chk("tx_full_count", tx_seen.size(), 17);
        for (int i = 0; i < 17 && i < tx_seen.size(); i++)
            chk("tx_full_data", int'(tx_seen[i]), int'(sent_tx[i]));

        // Asynchronous reset with RX in ack phase and TX in request phase.
        resp_en = 0;
        m_ready = 1'b0;
        rx_data = 8'h5A;
        rx_rq   = 1'b1;
        push_byte(8'h77);
        push_byte(8'h78);
        tick();
        chk("pre_rst_rx_st", int'(rx_st), 1);
        chk("pre_rst_tx_rq", int'(tx_rq), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rx_st", int'(rx_st), 0);
        chk("async_tx_rq", int'(tx_rq), 0);
        chk("async_rx_level", int'(rx_level), 0);
        chk("async_tx_level", int'(tx_level), 0);
        chk("async_m_valid", int'(m_valid), 0);
        chk("async_s_ready", int'(s_ready), 1);
        chk("async_tx_data", int'(tx_data), 0);
        rx_rq = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Concurrent random traffic in both directions.
        m_log.delete();
        tx_seen.delete();
        sent_rx.delete();
        sent_tx.delete();
        resp_en  = 1;
        resp_rnd = 1;
        fork
            for (int i = 0; i < 40; i++) begin
                logic [7:0] r;
                r = 8'($urandom);
                sent_rx.push_back(r);
                ftdi_send(r);
                repeat ($urandom_range(0, 2)) tick();
            end
            for (int i = 0; i < 40; i++) begin
                logic [7:0] t;
                t = 8'($urandom);
                sent_tx.push_back(t);
                push_byte(t);
                repeat ($urandom_range(0, 3)) tick();
            end
            for (int i = 0; i < 3000 && m_log.size() < 40; i++) begin
                m_ready = 1'($urandom_range(0, 1));
                tick();
            end
        join
        m_ready = 1'b1;
        wait_m_log(40);
        wait_tx_drain();
        chk("rand_rx_count", m_log.size(), 40);
        for (int i = 0; i < 40 && i < m_log.size(); i++)
            chk("rand_rx_data", int'(m_log[i]), int'(sent_rx[i]));
        chk("rand_tx_count", tx_seen.size(), 40);
        for (int i = 0; i < 40 && i < tx_seen.size(); i++)
            chk("rand_tx_data", int'(tx_seen[i]), int'(sent_tx[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ftdi_stream_bridge.md
FTDI_STREAM_BRIDGE -- requirements
Module: ftdi_stream_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning entries per FIFO (power of two, at least 2).
REQ-002 SHALL have parameter AW, default 4, meaning log2(DEPTH).
REQ-003 SHALL have port clock_in  in  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  in  8  byte from the FTDI block.
REQ-006 SHALL have port rx_rq  in  1  high while the FTDI block offers a byte.
REQ-007 SHALL have port rx_st  out  1  acknowledge to the FTDI block that the byte was taken.
REQ-008 SHALL have port tx_data  out  8  byte to the FTDI block.
REQ-009 SHALL have port tx_rq  out  1  high while tx_data is offered.
REQ-010 SHALL have port tx_st  in  1  FTDI block strobe meaning tx_data was latched.
REQ-011 SHALL have ports m_data  out  8, m_valid  out  1, m_ready  in  1, forming the stream of received bytes to the user logic.
REQ-012 SHALL have ports s_data  in  8, s_valid  in  1, s_ready  out  1, forming the stream of bytes from the user logic to transmit.
REQ-013 SHALL have ports rx_level  out  AW+1 and tx_level  out  AW+1, giving the occupancy of each FIFO.

Function
REQ-014 SHALL contain two independent FIFOs (RX and TX), each DEPTH x 8, with wrapping AW-bit pointers and an AW+1-bit count.
REQ-015 SHALL implement the RX FSM states R_IDLE and R_ACK: in R_IDLE, if rx_rq=1 and rx_level<DEPTH, write rx_data, set rx_st=1, go to R_ACK; in R_ACK, wait for rx_rq=0, then set rx_st=0 and go to R_IDLE.
REQ-016 SHALL, while the RX FIFO is full, leave rx_st low and store nothing, so the byte stays held by the FTDI block (no overflow, no loss).
REQ-017 SHALL drive m_valid = (rx_level!=0) and m_data = RX head; a pop occurs on the clock where m_valid&m_ready.
REQ-018 SHALL make a byte written on clock N visible on m_valid/m_data after clock N (1-cycle latency).
REQ-019 SHALL drive s_ready = (tx_level<DEPTH); a push occurs on the clock where s_valid&s_ready.
REQ-020 SHALL implement the TX FSM states T_IDLE, T_REQ and T_WAIT: in T_IDLE, if tx_level!=0, register tx_data=head, pop, set tx_rq=1, go to T_REQ; in T_REQ, on tx_st=1 set tx_rq=0 and go to T_WAIT; in T_WAIT, on tx_st=0 go to T_IDLE.
REQ-021 SHALL hold tx_data stable from tx_rq rising until the return to T_IDLE.
REQ-022 SHALL, on a simultaneous push and pop on one FIFO, leave the count unchanged and move both pointers.
REQ-023 SHALL evaluate the full check in R_IDLE on the pre-edge count: with a full FIFO and a simultaneous m_ready pop, the write is deferred one clock.
REQ-024 SHALL wrap pointers from DEPTH-1 to 0 with no data corruption.
REQ-025 SHALL keep rx_level and tx_level exact in the range 0..DEPTH and never exceed DEPTH.

Reset
REQ-026 SHALL, on reset assertion and independent of clock_in, clear pointers and counts, force both FSMs to their idle states, and drive rx_st=0, tx_rq=0, tx_data=0x00, m_valid=0, s_ready=1, rx_level=0, tx_level=0.
REQ-027 SHALL discard FIFO contents on reset asserted mid-transfer, and SHALL start no handshake until the first clock after reset deasserts.

Verification
REQ-028 SHALL cover: single RX byte 0xA5 with m_ready=1 -> rx_st high 1 clock after rx_rq is sampled, m_valid=1 with m_data=0xA5 the next clock, rx_st low after rx_rq falls.
REQ-029 SHALL cover: 17 RX bytes 0x00..0x10 with m_ready=0 (DEPTH=16) -> rx_level=16, 17th byte never acknowledged; raise m_ready -> 0x10 accepted, output order 0x00..0x10.
REQ-030 SHALL cover: s_valid burst 0x01,0x02,0x03 with FTDI model strobing tx_st -> tx_rq drops after each tx_st, tx_data sequence 0x01,0x02,0x03, tx_level returns to 0.
REQ-031 SHALL cover: TX FIFO filled to 16 -> s_ready=0, 17th s_data not stored; one transmit completes -> s_ready=1.
REQ-032 SHALL cover: reset asserted in R_ACK and T_REQ -> rx_st=0, tx_rq=0, both levels 0 immediately without a clock edge.
REQ-033 SHALL cover: 40 concurrent random bytes each way, including wrap-around -> data matches a scoreboard, no loss or duplication.
